cla_add_pipe: RTL and testbench

Registered, flow-controlled front/back end for the 32-bit `carry_look_ahead_adder`. It accepts operand transactions over a valid/ready handshake and registers the operands into an input stage that drives the combinational adder instance. It captures sum, carry-out and derived flags into an output stage. It is the upstream/downstream wrapper that lets the adder sit in a pipelined datapath without a long combinational path from source to sink.

---
 rtl/cla_add_pipe_if.sv | 29 ++
 rtl/cla_add_pipe.sv | 221 ++++++++++++++++++++++
 tb/tb_cla_add_pipe.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/cla_add_pipe_if.sv
// Handshake/data bundle for cla_add_pipe: operand request channel (in_*)
// and result channel (out_*). The source/sink side uses the master modport;
// the pipeline itself uses the slave modport.
interface cla_add_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_zero;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_zero, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_zero, out_ovf
    );
endinterface

// File: rtl/cla_add_pipe.sv
// cla_add_pipe: two-stage registered wrapper around a 32-bit carry
// look-ahead adder. S1 holds the effective operands (B already inverted and
// carry-in forced for subtract) and feeds the adder with no logic in between;
// S2 captures sum, carry-out, zero and signed-overflow flags.
// Optional feature macro: CLA_PIPE_SKID_EN adds a one-entry skid buffer in
// front of S1 so in_ready no longer depends combinationally on out_ready.

// 32-bit adder built from eight 4-bit look-ahead groups; group carries are
// resolved from group generate/propagate terms.
module carry_look_ahead_adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    logic [31:0] p;
    logic [31:0] g;
    logic [7:0]  grp_p;
    logic [7:0]  grp_g;
    logic [8:0]  grp_c;

    assign p = a ^ b;
    assign g = a & b;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_grp
            localparam int B = 4 * gi;
            logic ci;
            logic c1;
            logic c2;
            logic c3;

            assign grp_p[gi] = &p[B+3:B];
            assign grp_g[gi] = g[B+3]
                             | (p[B+3] & g[B+2])
                             | (p[B+3] & p[B+2] & g[B+1])
                             | (p[B+3] & p[B+2] & p[B+1] & g[B]);

            assign ci = grp_c[gi];
            assign c1 = g[B] | (p[B] & ci);
            assign c2 = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & ci);
            assign c3 = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                      | (p[B+2] & p[B+1] & p[B] & ci);

            assign sum[B+3:B] = p[B+3:B] ^ {c3, c2, c1, ci};
        end
    endgenerate

    // Second-level look-ahead: carries into each 4-bit group.
    always_comb begin
        grp_c    = '0;
        grp_c[0] = cin;
        for (int i = 0; i < 8; i++) begin
            grp_c[i+1] = grp_g[i] | (grp_p[i] & grp_c[i]);
        end
    end

    assign cout = grp_c[8];
endmodule

module cla_add_pipe #(
    parameter int WIDTH = 32    // must stay 32 to match the adder
) (
    input  logic              clk,
    input  logic              rst,
    cla_add_pipe_if.slave     bus
);
    // S1 operand stage
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic             s1_cin_q, s1_cin_d;
    // S2 result stage
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_sum_q, s2_sum_d;
    logic             s2_cout_q, s2_cout_d;
    logic             s2_zero_q, s2_zero_d;
    logic             s2_ovf_q, s2_ovf_d;

    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic             s2_load;
    logic             s1_free;
    logic             accept;
    logic             in_ready_int;
    logic [WIDTH-1:0] in_b_eff;
    logic             in_cin_eff;

    carry_look_ahead_adder u_adder (
        .a    (s1_a_q),
        .b    (s1_b_q),
        .cin  (s1_cin_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

`ifdef CLA_PIPE_SKID_EN
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_a_q, skid_a_d;
    logic [WIDTH-1:0] skid_b_q, skid_b_d;
    logic             skid_cin_q, skid_cin_d;
`endif

    // Advance/accept decisions and next-state for both stages.
    always_comb begin
        s2_load    = s1_valid_q && (!s2_valid_q || bus.out_ready);
        s1_free    = !s1_valid_q || s2_load;
        in_b_eff   = bus.in_sub ? ~bus.in_b : bus.in_b;
        in_cin_eff = bus.in_sub ? 1'b1 : bus.in_cin;

        s1_valid_d = s1_valid_q && !s2_load;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_cin_d   = s1_cin_q;

`ifdef CLA_PIPE_SKID_EN
        in_ready_int = !rst && !skid_valid_q;
        accept       = bus.in_valid && in_ready_int;
        skid_valid_d = skid_valid_q;
        skid_a_d     = skid_a_q;
        skid_b_d     = skid_b_q;
        skid_cin_d   = skid_cin_q;
        if (skid_valid_q) begin
            // A parked transaction always goes ahead of new input.
            if (s1_free) begin
                s1_valid_d   = 1'b1;
                s1_a_d       = skid_a_q;
                s1_b_d       = skid_b_q;
                s1_cin_d     = skid_cin_q;
                skid_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (s1_free) begin
                s1_valid_d = 1'b1;
                s1_a_d     = bus.in_a;
                s1_b_d     = in_b_eff;
                s1_cin_d   = in_cin_eff;
            end else begin
                skid_valid_d = 1'b1;
                skid_a_d     = bus.in_a;
                skid_b_d     = in_b_eff;
                skid_cin_d   = in_cin_eff;
            end
        end
`else
        in_ready_int = !rst && s1_free;
        accept       = bus.in_valid && in_ready_int;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_a_d     = bus.in_a;
            s1_b_d     = in_b_eff;
            s1_cin_d   = in_cin_eff;
        end
`endif

        s2_valid_d = s2_valid_q && !bus.out_ready;
        s2_sum_d   = s2_sum_q;
        s2_cout_d  = s2_cout_q;
        s2_zero_d  = s2_zero_q;
        s2_ovf_d   = s2_ovf_q;
        if (s2_load) begin
            s2_valid_d = 1'b1;
            s2_sum_d   = add_sum;
            s2_cout_d  = add_cout;
            s2_zero_d  = ~|add_sum;
            s2_ovf_d   = (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1]) &&
                         (add_sum[WIDTH-1] != s1_a_q[WIDTH-1]);
        end
    end

    // Pipeline registers; reset discards everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_cin_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_sum_q   <= '0;
            s2_cout_q  <= 1'b0;
            s2_zero_q  <= 1'b0;
            s2_ovf_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_cin_q   <= s1_cin_d;
            s2_valid_q <= s2_valid_d;
            s2_sum_q   <= s2_sum_d;
            s2_cout_q  <= s2_cout_d;
            s2_zero_q  <= s2_zero_d;
            s2_ovf_q   <= s2_ovf_d;
        end
    end

`ifdef CLA_PIPE_SKID_EN
    // Skid buffer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            skid_valid_q <= 1'b0;
            skid_a_q     <= '0;
            skid_b_q     <= '0;
            skid_cin_q   <= 1'b0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_a_q     <= skid_a_d;
            skid_b_q     <= skid_b_d;
            skid_cin_q   <= skid_cin_d;
        end
    end
`endif

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = s2_valid_q;
    assign bus.out_sum   = s2_sum_q;
    assign bus.out_cout  = s2_cout_q;
    assign bus.out_zero  = s2_zero_q;
    assign bus.out_ovf   = s2_ovf_q;
endmodule

// File: tb/tb_cla_add_pipe.sv
// Directed testbench for cla_add_pipe. Inputs are driven 1 time unit after
// the rising edge and outputs sampled 2 time units after it.
// Honours CLA_PIPE_SKID_EN for the backpressure acceptance count.
module tb_cla_add_pipe;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    cla_add_pipe_if #(.WIDTH(32)) bus ();

    cla_add_pipe #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic chk_res(input string tag, input logic [31:0] s, input logic c,
                           input logic z, input logic o);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_sum"},   bus.out_sum, s);
        chk({tag, "_cout"},  32'(bus.out_cout), 32'(c));
        chk({tag, "_zero"},  32'(bus.out_zero), 32'(z));
        chk({tag, "_ovf"},   32'(bus.out_ovf), 32'(o));
        $display("txn %s sum=%h cout=%0b zero=%0b ovf=%0b", tag,
                 bus.out_sum, bus.out_cout, bus.out_zero, bus.out_ovf);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic sub);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_cin   = cin;
        bus.in_sub   = sub;
    endtask

    // Present one transaction, wait (bounded) until accepted, then idle input.
    task automatic send_one(input logic [31:0] a, input logic [31:0] b,
                            input logic cin, input logic sub);
        int n;
        drive(a, b, cin, sub);
        #1;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("send_accept", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    logic [31:0] bp_a    [4] = '{32'd1, 32'd3, 32'd100, 32'hFFFF_FFFF};
    logic [31:0] bp_b    [4] = '{32'd2, 32'd4, 32'd200, 32'd1};
    logic        bp_cin  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] bp_sum  [4] = '{32'd3, 32'd7, 32'd301, 32'd0};
    logic        bp_cout [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic        bp_zero [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

`ifdef CLA_PIPE_SKID_EN
    localparam int EXP_ACC = 3;
`else
    localparam int EXP_ACC = 2;
`endif

    initial begin
        int iidx;
        int oidx;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_cin    = 1'b0;
        bus.in_sub    = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        tick();
        tick();
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_sum",   bus.out_sum, 32'd0);
        chk("rst_out_cout",  32'(bus.out_cout), 32'd0);
        chk("rst_out_zero",  32'(bus.out_zero), 32'd0);
        chk("rst_out_ovf",   32'(bus.out_ovf), 32'd0);
        chk("rst_in_ready",  32'(bus.in_ready), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Basic add with latency check
        tick();
        send_one(32'd10, 32'd20, 1'b0, 1'b0);
        #1;
        chk("basic_latency", 32'(bus.out_valid), 32'd0);
        tick();
        #1;
        chk_res("basic_add", 32'd30, 1'b0, 1'b0, 1'b0);

        // Back-to-back stream
        tick();
        drive(32'd9, 32'd11, 1'b1, 1'b0);
        tick();
        drive(32'h0FFF_FFFF, 32'd1, 1'b0, 1'b0);
        tick();
        drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        #1;
        chk_res("stream0", 32'd21, 1'b0, 1'b0, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        #1;
        chk_res("stream1", 32'h1000_0000, 1'b0, 1'b0, 1'b0);
        tick();
        #1;
        chk_res("stream2", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        tick();
        #1;
        chk("stream_drained", 32'(bus.out_valid), 32'd0);

        // Subtract and flags (cin deliberately 0 on the subtracts)
        tick();
        drive(32'd5, 32'd7, 1'b0, 1'b1);
        tick();
        drive(32'd7, 32'd7, 1'b0, 1'b1);
        tick();
        drive(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
        #1;
        chk_res("sub_5_7", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        #1;
        chk_res("sub_7_7", 32'd0, 1'b1, 1'b1, 1'b0);
        tick();
        #1;
        chk_res("add_ovf", 32'h8000_0000, 1'b0, 1'b0, 1'b1);

        // Backpressure: out_ready low for 5 cycles while streaming 4 txns
        tick();
        iidx = 0;
        oidx = 0;
        for (int cyc = 0; cyc < 40 && oidx < 4; cyc++) begin
            bus.out_ready = (cyc >= 5);
            if (iidx < 4) drive(bp_a[iidx], bp_b[iidx], bp_cin[iidx], 1'b0);
            else          bus.in_valid = 1'b0;
            #1;
            if (cyc == 5) chk("bp_accepted", 32'(iidx), 32'(EXP_ACC));
            if (cyc >= 2 && cyc <= 4) begin
                chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
                chk("bp_hold_sum",   bus.out_sum, 32'd3);
                chk("bp_in_ready",   32'(bus.in_ready),
                    32'((cyc == 2) && (EXP_ACC == 3)));
            end
            if (bus.out_valid && bus.out_ready) begin
                chk_res($sformatf("bp%0d", oidx), bp_sum[oidx], bp_cout[oidx],
                        bp_zero[oidx], 1'b0);
                oidx++;
            end
            if (bus.in_valid && bus.in_ready) iidx++;
            tick();
        end
        chk("bp_all_results", 32'(oidx), 32'd4);
        bus.in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_no_duplicate", 32'(bus.out_valid), 32'd0);
            tick();
        end

        // Reset with both stages full
        bus.out_ready = 1'b0;
        send_one(32'd1, 32'd1, 1'b0, 1'b0);
        send_one(32'd2, 32'd2, 1'b0, 1'b0);
        #1;
        chk("full_out_sum", bus.out_sum, 32'd2);
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_out_sum",   bus.out_sum, 32'd0);
        chk("midrst_out_cout",  32'(bus.out_cout), 32'd0);
        chk("midrst_out_zero",  32'(bus.out_zero), 32'd0);
        chk("midrst_out_ovf",   32'(bus.out_ovf), 32'd0);
        chk("midrst_in_ready1", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            #1;
            chk("midrst_no_stale", 32'(bus.out_valid), 32'd0);
        end
        tick();
        send_one(32'd3, 32'd4, 1'b0, 1'b0);
        tick();
        #1;
        chk_res("after_rst", 32'd7, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
